// File: rtl/led_cfg_arbiter.sv
// Two-requester AXI4-Lite master sharing the LED driver register bank.
// Round-robin grant, one outstanding single-beat transaction, response routed back to the issuer.
module led_cfg_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_NUM_REGS   = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_wr,
  input  logic [2*C_ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]               req_wdata,
  output logic [1:0]                rsp_valid,
  output logic [31:0]               rsp_data,
  output logic [1:0]                rsp_resp,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

  localparam logic [C_ADDR_WIDTH:0] ADDR_LIMIT = (C_ADDR_WIDTH+1)'(4 * C_NUM_REGS);

  state_t                    state, state_next;
  logic                      last_id;
  logic                      cur_id;
  logic                      grant_id;
  logic                      grant_fire;
  logic                      sel_wr;
  logic [C_ADDR_WIDTH-1:0]   sel_addr;
  logic [31:0]               sel_wdata;
  logic                      addr_ok;
  logic                      aw_done;
  logic                      w_done;

  assign m_axi_wstrb = 4'hF;

  // When both requesters are pending, the one not served last wins.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid[0] && req_valid[1])
      grant_id = ~last_id;
    else if (req_valid[1])
      grant_id = 1'b1;

    req_ready = 2'b00;
    if (ARESETN && (state == IDLE) && (req_valid != 2'b00))
      req_ready = grant_id ? 2'b10 : 2'b01;

    grant_fire = (req_ready != 2'b00);
    sel_wr     = grant_id ? req_wr[1] : req_wr[0];
    sel_addr   = grant_id ? req_addr[C_ADDR_WIDTH +: C_ADDR_WIDTH] : req_addr[0 +: C_ADDR_WIDTH];
    sel_wdata  = grant_id ? req_wdata[63:32] : req_wdata[31:0];
    addr_ok    = (sel_addr[1:0] == 2'b00) && ({1'b0, sel_addr} < ADDR_LIMIT);
  end

  assign aw_done   = !m_axi_awvalid || m_axi_awready;
  assign w_done    = !m_axi_wvalid || m_axi_wready;
  assign rsp_valid = (state == RSP) ? (cur_id ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge ACLK) begin
    if (!ARESETN)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_fire) begin
          if (!addr_ok)
            state_next = RSP;
          else if (sel_wr)
            state_next = WR;
          else
            state_next = RA;
        end
      end
      WR:      if (aw_done && w_done) state_next = WB;
      WB:      if (m_axi_bvalid) state_next = RSP;
      RA:      if (m_axi_arready) state_next = RD;
      RD:      if (m_axi_rvalid) state_next = RSP;
      RSP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // AXI channel registers double as the captured request; each valid falls on its own handshake.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      last_id       <= 1'b1;
      cur_id        <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_data      <= '0;
      rsp_resp      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_fire) begin
            cur_id  <= grant_id;
            last_id <= grant_id;
            if (!addr_ok) begin
              rsp_data <= '0;
              rsp_resp <= 2'b10;
            end else if (sel_wr) begin
              m_axi_awaddr  <= sel_addr;
              m_axi_wdata   <= sel_wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              m_axi_araddr  <= sel_addr;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready) m_axi_wvalid <= 1'b0;
          if (aw_done && w_done) m_axi_bready <= 1'b1;
        end
        WB: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_data     <= '0;
            rsp_resp     <= m_axi_bresp;
          end
        end
        RA: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        RD: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_data     <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_cfg_arbiter.sv
// Directed bench for led_cfg_arbiter: vector table plus hand sequences for
// round-robin, slow AWREADY and reset mid-transaction, against a behavioural slave.
module tb_led_cfg_arbiter;

  localparam int A = 5;

  logic          ACLK;
  logic          ARESETN;
  logic [1:0]    req_valid, req_ready, req_wr;
  logic [2*A-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic [1:0]    rsp_valid;
  logic [31:0]   rsp_data;
  logic [1:0]    rsp_resp;
  logic [A-1:0]  m_axi_awaddr, m_axi_araddr;
  logic          m_axi_awvalid, m_axi_awready;
  logic [31:0]   m_axi_wdata, m_axi_rdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;

  int n_compared = 0;
  int n_mismatched = 0;

  led_cfg_arbiter #(.C_ADDR_WIDTH(A), .C_NUM_REGS(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Behavioural slave, updated on the falling edge so the DUT sees stable inputs.
  logic [31:0] mem [8];
  int          aw_delay = 0;
  logic [1:0]  rresp_force = 2'b00;
  int          aw_wait = 0;
  int          b_hs_cnt = 0;
  int          axi_act_cnt = 0;
  bit          got_aw = 0, got_w = 0, got_ar = 0;
  logic [A-1:0] wr_addr, rd_addr;
  logic [31:0] wr_data;

  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
  end

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      m_axi_arready = 0; m_axi_rvalid = 0;
      got_aw = 0; got_w = 0; got_ar = 0; aw_wait = 0;
    end else begin
      if (got_aw && got_w && m_axi_bready) begin
        m_axi_bvalid = 1; m_axi_bresp = 2'b00;
        mem[wr_addr[4:2]] = wr_data;
        got_aw = 0; got_w = 0; b_hs_cnt++;
      end else m_axi_bvalid = 0;
      if (got_ar && m_axi_rready) begin
        m_axi_rvalid = 1; m_axi_rdata = mem[rd_addr[4:2]]; m_axi_rresp = rresp_force;
        got_ar = 0;
      end else m_axi_rvalid = 0;
      if (m_axi_awvalid && !got_aw) begin
        m_axi_awready = (aw_wait >= aw_delay);
        aw_wait++;
        if (m_axi_awready) begin got_aw = 1; wr_addr = m_axi_awaddr; aw_wait = 0; end
      end else m_axi_awready = 0;
      if (m_axi_wvalid && !got_w) begin
        m_axi_wready = 1; got_w = 1; wr_data = m_axi_wdata;
      end else m_axi_wready = 0;
      if (m_axi_arvalid && !got_ar) begin
        m_axi_arready = 1; got_ar = 1; rd_addr = m_axi_araddr;
      end else m_axi_arready = 0;
      if (m_axi_awvalid || m_axi_arvalid) axi_act_cnt++;
    end
  end

  typedef struct {
    logic        id;
    logic        wr;
    logic [A-1:0] addr;
    logic [31:0] wdata;
    logic [1:0]  rresp;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_lat;
    logic        exp_axi;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mkVec(logic id, logic wr, logic [A-1:0] addr, logic [31:0] wdata,
                                 logic [1:0] rresp, logic [31:0] exp_data, logic [1:0] exp_resp,
                                 int exp_lat, logic exp_axi);
    vec_t v;
    v.id = id; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rresp = rresp;
    v.exp_data = exp_data; v.exp_resp = exp_resp; v.exp_lat = exp_lat; v.exp_axi = exp_axi;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic resetDut();
    @(negedge ACLK); #1 ARESETN = 0;
    repeat (2) @(negedge ACLK);
    #1 ARESETN = 1;
  endtask

  // Presents one request and returns just after the capture edge.
  task automatic issueReq(input int id, input logic wr, input logic [A-1:0] addr,
                          input logic [31:0] wdata);
    int waited = 0;
    @(negedge ACLK);
    req_wr[id] = wr;
    req_addr[id*A +: A] = addr;
    req_wdata[id*32 +: 32] = wdata;
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && waited < 20) begin
      @(negedge ACLK); #1; waited++;
    end
    checkOutput("grant", {31'b0, req_ready[id]}, 32'd1);
    @(posedge ACLK); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic waitRsp(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge ACLK);
      lat++;
      if (rsp_valid != 2'b00) break;
    end
  endtask

  task automatic applyStimulus(input int i);
    vec_t v = vecs[i];
    int lat, act0;
    rresp_force = v.rresp;
    act0 = axi_act_cnt;
    issueReq(int'(v.id), v.wr, v.addr, v.wdata);
    waitRsp(lat);
    checkOutput($sformatf("vec%0d_latency", i), lat, v.exp_lat);
    checkOutput($sformatf("vec%0d_rsp_valid", i), {30'b0, rsp_valid}, v.id ? 32'd2 : 32'd1);
    checkOutput($sformatf("vec%0d_rsp_data", i), rsp_data, v.exp_data);
    checkOutput($sformatf("vec%0d_rsp_resp", i), {30'b0, rsp_resp}, {30'b0, v.exp_resp});
    @(negedge ACLK);
    checkOutput($sformatf("vec%0d_pulse_width", i), {30'b0, rsp_valid}, 32'd0);
    checkOutput($sformatf("vec%0d_axi_traffic", i), {31'b0, (axi_act_cnt != act0)}, {31'b0, v.exp_axi});
    rresp_force = 2'b00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int grants, pulses, lat, b0, awv, wv, addr_bad, data_bad, rsp_cnt, rsp_lat;

    vecs[0]  = mkVec(0, 1, 5'h00, 32'd1, 2'b00, 32'd0, 2'b00, 3, 1);
    vecs[1]  = mkVec(0, 1, 5'h04, 32'd2, 2'b00, 32'd0, 2'b00, 3, 1);
    vecs[2]  = mkVec(0, 1, 5'h08, 32'd3, 2'b00, 32'd0, 2'b00, 3, 1);
    vecs[3]  = mkVec(0, 1, 5'h0C, 32'd4, 2'b00, 32'd0, 2'b00, 3, 1);
    vecs[4]  = mkVec(0, 0, 5'h00, 32'd0, 2'b00, 32'd1, 2'b00, 3, 1);
    vecs[5]  = mkVec(0, 0, 5'h04, 32'd0, 2'b00, 32'd2, 2'b00, 3, 1);
    vecs[6]  = mkVec(0, 0, 5'h08, 32'd0, 2'b00, 32'd3, 2'b00, 3, 1);
    vecs[7]  = mkVec(0, 0, 5'h0C, 32'd0, 2'b00, 32'd4, 2'b00, 3, 1);
    vecs[8]  = mkVec(1, 0, 5'h04, 32'd0, 2'b00, 32'd2, 2'b00, 3, 1);
    vecs[9]  = mkVec(1, 1, 5'h10, 32'hAA, 2'b00, 32'd0, 2'b10, 1, 0);
    vecs[10] = mkVec(0, 0, 5'h02, 32'd0, 2'b00, 32'd0, 2'b10, 1, 0);
    vecs[11] = mkVec(1, 1, 5'h0C, 32'hDEADBEEF, 2'b00, 32'd0, 2'b00, 3, 1);
    vecs[12] = mkVec(0, 0, 5'h0C, 32'd0, 2'b00, 32'hDEADBEEF, 2'b00, 3, 1);
    vecs[13] = mkVec(1, 0, 5'h08, 32'd0, 2'b11, 32'd3, 2'b11, 3, 1);
    vecs[14] = mkVec(0, 0, 5'h1F, 32'd0, 2'b00, 32'd0, 2'b10, 1, 0);

    ARESETN = 0; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge ACLK);
    checkOutput("reset_ctrl", {11'b0, req_ready, rsp_valid, rsp_resp, m_axi_awvalid, m_axi_wvalid,
                m_axi_bready, m_axi_arvalid, m_axi_rready, m_axi_awaddr, m_axi_araddr}, 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_wdata", m_axi_wdata, 32'd0);
    checkOutput("wstrb", {28'b0, m_axi_wstrb}, 32'hF);
    #1 ARESETN = 1;

    for (int i = 0; i < 15; i++) applyStimulus(i);

    // Both requesters pending continuously from reset: grants must alternate.
    resetDut();
    @(negedge ACLK);
    req_wr = 2'b01;
    req_addr = {5'h08, 5'h04};
    req_wdata = {32'h0, 32'h55};
    req_valid = 2'b11;
    grants = 0; pulses = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (req_ready != 2'b00 && grants < 4) begin
        checkOutput($sformatf("alt_grant%0d", grants), {30'b0, req_ready}, (grants % 2) ? 32'd2 : 32'd1);
        grants++;
      end
      if (rsp_valid != 2'b00) begin
        checkOutput($sformatf("alt_pulse%0d", pulses), {30'b0, rsp_valid}, (pulses % 2) ? 32'd2 : 32'd1);
        if (rsp_valid[1]) checkOutput($sformatf("alt_rdata%0d", pulses), rsp_data, 32'd3);
        pulses++;
        if (pulses == 4) break;
      end
      @(negedge ACLK);
    end
    req_valid = 2'b00;
    checkOutput("alt_pulse_count", pulses, 4);
    checkOutput("alt_grant_count", grants, 4);

    // AWREADY three cycles late, WREADY immediate.
    aw_delay = 3;
    b0 = b_hs_cnt;
    issueReq(0, 1'b1, 5'h08, 32'h77);
    awv = 0; wv = 0; addr_bad = 0; data_bad = 0; rsp_cnt = 0; rsp_lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge ACLK);
      if (m_axi_awvalid) begin awv++; if (m_axi_awaddr != 5'h08) addr_bad++; end
      if (m_axi_wvalid) begin wv++; if (m_axi_wdata != 32'h77) data_bad++; end
      if (rsp_valid != 2'b00) begin rsp_cnt++; rsp_lat = c; end
    end
    aw_delay = 0;
    checkOutput("awdly_awvalid_cycles", awv, 4);
    checkOutput("awdly_wvalid_cycles", wv, 1);
    checkOutput("awdly_awaddr_unstable", addr_bad, 0);
    checkOutput("awdly_wdata_unstable", data_bad, 0);
    checkOutput("awdly_b_count", b_hs_cnt - b0, 1);
    checkOutput("awdly_rsp_count", rsp_cnt, 1);
    checkOutput("awdly_rsp_latency", rsp_lat, 6);

    // Reset while waiting for B, from requester 0 so the pointer would otherwise favour 1.
    issueReq(0, 1'b1, 5'h04, 32'h99);
    @(negedge ACLK);
    @(negedge ACLK);
    checkOutput("wb_bready", {31'b0, m_axi_bready}, 32'd1);
    #1 ARESETN = 0;
    @(negedge ACLK);
    checkOutput("wb_reset_ctrl", {23'b0, req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid,
                m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'd0);
    #1 ARESETN = 1;
    rsp_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      if (rsp_valid != 2'b00) rsp_cnt++;
    end
    checkOutput("wb_reset_no_rsp", rsp_cnt, 0);
    req_wr = 2'b00;
    req_addr = {5'h04, 5'h00};
    req_valid = 2'b11;
    #1;
    checkOutput("post_reset_grant", {30'b0, req_ready}, 32'd1);
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    waitRsp(lat);
    checkOutput("post_reset_latency", lat, 3);
    checkOutput("post_reset_rsp_valid", {30'b0, rsp_valid}, 32'd1);
    checkOutput("post_reset_rsp_data", rsp_data, 32'd1);
    checkOutput("post_reset_rsp_resp", {30'b0, rsp_resp}, 32'd0);

    repeat (2) @(negedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
